// File: rtl/key_sequence_lock_if.sv
// Pin bundle of the combination lock: raw buttons in, display and status out.
interface key_sequence_lock_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] KEY;
    logic [6:0]          HEX0;
    logic                UNLOCKED;
    logic                LOCKED_OUT;
    logic [3:0]          FAIL_COUNT;

    modport slave  (input KEY, output HEX0, UNLOCKED, LOCKED_OUT, FAIL_COUNT);
    modport master (output KEY, input HEX0, UNLOCKED, LOCKED_OUT, FAIL_COUNT);
endinterface

// File: rtl/key_sequence_lock.sv
// Push-button combination lock: per-key sync + debounce, entry FSM with
// timeouts, failure counting and lockout, seven-segment status display.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    // only a debounced fall (release -> press) is an event
                    press <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module key_sequence_lock #(
    parameter int NUM_KEYS = 3,
    parameter int SEQ_LEN  = 4,
    localparam int IDXW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    parameter logic [SEQ_LEN*IDXW-1:0] CODE = {2'd2, 2'd0, 2'd1, 2'd0},
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int OPEN_CYCLES     = 150000000,
    parameter int ERROR_CYCLES    = 50000000,
    parameter int LOCKOUT_CYCLES  = 500000000,
    parameter int MAX_FAILS       = 3
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    key_sequence_lock_if.slave  io
);
    localparam int SW = $clog2(SEQ_LEN + 1);
    localparam int TW = 32;

    typedef enum logic [2:0] {IDLE, ENTRY, OPEN, ERROR, LOCKOUT} state_t;

    logic [NUM_KEYS-1:0] press;
    state_t              state, state_n;
    logic [SW-1:0]       step, step_n;
    logic [3:0]          fail_cnt, fail_n;
    logic [TW-1:0]       timer, timer_n;
    logic [IDXW-1:0]     press_idx, exp_idx;
    logic                press_any, correct, expire;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (CLOCK_50),
            .rst_n (RESET_N),
            .key_n (io.KEY[k]),
            .press (press[k])
        );
    end

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (press[i]) press_idx = IDXW'(i);
        exp_idx = '0;
        for (int i = 0; i < SEQ_LEN; i++)
            if (step == SW'(i)) exp_idx = CODE[i*IDXW +: IDXW];
    end

    // several keys in one cycle is never a valid step
    assign press_any = |press;
    assign correct   = $onehot(press) && (press_idx == exp_idx);
    assign expire    = (timer == TW'(1));

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state    <= IDLE;
            step     <= '0;
            fail_cnt <= '0;
            timer    <= '0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            fail_cnt <= fail_n;
            timer    <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        fail_n  = fail_cnt;
        timer_n = (timer != '0) ? timer - 1'b1 : '0;
        case (state)
            IDLE, ENTRY: begin
                if (press_any) begin
                    if (!correct) begin
                        state_n = ERROR;
                        step_n  = '0;
                        timer_n = TW'(ERROR_CYCLES);
                        fail_n  = (fail_cnt == 4'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;
                    end else if (int'(step) + 1 == SEQ_LEN) begin
                        state_n = OPEN;
                        step_n  = '0;
                        timer_n = TW'(OPEN_CYCLES);
                        fail_n  = '0;
                    end else begin
                        state_n = ENTRY;
                        step_n  = step + 1'b1;
                        timer_n = TW'(TIMEOUT_CYCLES);
                    end
                end else if (state == ENTRY && expire) begin
                    state_n = IDLE;
                    step_n  = '0;
                end
            end
            OPEN: begin
                if (press_any || expire) state_n = IDLE;
            end
            ERROR: begin
                if (fail_cnt == 4'(MAX_FAILS)) begin
                    state_n = LOCKOUT;
                    timer_n = TW'(LOCKOUT_CYCLES);
                end else if (expire) begin
                    state_n = IDLE;
                end
            end
            LOCKOUT: begin
                if (expire) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                step_n  = '0;
                timer_n = '0;
            end
        endcase
    end

    function automatic logic [6:0] digit(input logic [3:0] d);
        case (d)
            4'd0:    digit = 7'b1000000;
            4'd1:    digit = 7'b1111001;
            4'd2:    digit = 7'b0100100;
            4'd3:    digit = 7'b0110000;
            4'd4:    digit = 7'b0011001;
            4'd5:    digit = 7'b0010010;
            4'd6:    digit = 7'b0000010;
            4'd7:    digit = 7'b1111000;
            4'd8:    digit = 7'b0000000;
            default: digit = 7'b0010000;
        endcase
    endfunction

    always_comb begin
        case (state)
            ENTRY:   io.HEX0 = digit(4'(step));
            OPEN:    io.HEX0 = 7'b1000001;
            ERROR:   io.HEX0 = 7'b0000110;
            LOCKOUT: io.HEX0 = 7'b1000111;
            default: io.HEX0 = 7'b0111111;
        endcase
    end

    assign io.UNLOCKED   = (state == OPEN);
    assign io.LOCKED_OUT = (state == LOCKOUT);
    assign io.FAIL_COUNT = fail_cnt;
endmodule

// File: tb/tb_key_sequence_lock.sv
// Scoreboard bench: each stimulus queues the output tuple and the cycle it must appear on.
module tb_key_sequence_lock;
    localparam logic [6:0] H_DASH = 7'b0111111, H_1 = 7'b1111001, H_2 = 7'b0100100,
                           H_3 = 7'b0110000, H_U = 7'b1000001, H_E = 7'b0000110,
                           H_L = 7'b1000111;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    key_sequence_lock_if #(.NUM_KEYS(3)) io();

    key_sequence_lock #(
        .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50), .OPEN_CYCLES(20),
        .ERROR_CYCLES(10), .LOCKOUT_CYCLES(30)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .io       (io)
    );

    typedef struct {
        int          cyc;
        logic [12:0] val;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          t;
    bit          mon_en = 1'b0;
    logic [12:0] prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_at(input string tag, input int c, input logic [6:0] hex,
                             input logic unl, input logic lo, input logic [3:0] fc);
        exp_t e;
        e.cyc = c;
        e.val = {hex, unl, lo, fc};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // hold long enough to debounce, release, and let the release settle
    task automatic press(input logic [2:0] m);
        io.KEY = io.KEY & ~m;
        idle(8);
        io.KEY = io.KEY | m;
        idle(10);
    endtask

    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    initial begin : monitor
        logic [12:0] cur;
        exp_t        e;
        string       tg;
        forever begin
            @(negedge CLOCK_50);
            if (mon_en) begin
                cur = {io.HEX0, io.UNLOCKED, io.LOCKED_OUT, io.FAIL_COUNT};
                if (cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious change", 32'(cur), 32'(prev));
                    end else begin
                        e  = exp_q.pop_front();
                        tg = tag_q.pop_front();
                        chk(tg, 32'(cur), 32'(e.val));
                        chk({tg, " cycle"}, cyc, e.cyc);
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        io.KEY  = 3'b111;
        RESET_N = 1'b0;
        idle(3);
        chk("reset hex", 32'(io.HEX0), 32'(H_DASH));
        chk("reset unlocked", 32'(io.UNLOCKED), 0);
        chk("reset locked_out", 32'(io.LOCKED_OUT), 0);
        chk("reset fail_count", 32'(io.FAIL_COUNT), 0);
        RESET_N = 1'b1;
        prev    = {H_DASH, 1'b0, 1'b0, 4'd0};
        mon_en  = 1'b1;
        idle(3);

        // correct code 0,1,0,2 then OPEN expires
        t = cyc; expect_at("code step1", t + 7, H_1, 0, 0, 0); press(3'b001);
        t = cyc; expect_at("code step2", t + 7, H_2, 0, 0, 0); press(3'b010);
        t = cyc; expect_at("code step3", t + 7, H_3, 0, 0, 0); press(3'b001);
        t = cyc;
        expect_at("open", t + 7, H_U, 1, 0, 0);
        expect_at("open expiry", t + 27, H_DASH, 0, 0, 0);
        press(3'b100);
        idle(12);

        // bounce on key 0: one press only, then entry times out
        for (int i = 0; i < 7; i++) begin
            io.KEY[0] = (i % 2 == 1);
            if (i < 6) idle(2);
        end
        t = cyc;
        expect_at("bounce press", t + 7, H_1, 0, 0, 0);
        expect_at("bounce timeout", t + 57, H_DASH, 0, 0, 0);
        idle(10);
        io.KEY[0] = 1'b1;
        idle(55);

        // three wrong presses -> lockout; a press during lockout is dropped
        t = cyc; expect_at("err1", t + 7, H_E, 0, 0, 1);
        expect_at("err1 end", t + 17, H_DASH, 0, 0, 1); press(3'b100);
        t = cyc; expect_at("err2", t + 7, H_E, 0, 0, 2);
        expect_at("err2 end", t + 17, H_DASH, 0, 0, 2); press(3'b100);
        t = cyc; expect_at("err3", t + 7, H_E, 0, 0, 3);
        expect_at("lockout", t + 8, H_L, 0, 1, 3);
        expect_at("lockout end", t + 38, H_DASH, 0, 0, 0);
        press(3'b100);
        press(3'b001);
        idle(10);

        // entry timeout after 0,1, then a fresh start
        t = cyc; expect_at("tmo step1", t + 7, H_1, 0, 0, 0); press(3'b001);
        t = cyc; expect_at("tmo step2", t + 7, H_2, 0, 0, 0);
        expect_at("tmo idle", t + 57, H_DASH, 0, 0, 0);
        press(3'b010);
        idle(45);
        t = cyc; expect_at("tmo restart", t + 7, H_1, 0, 0, 0);
        expect_at("tmo restart idle", t + 57, H_DASH, 0, 0, 0);
        press(3'b001);
        idle(45);

        // keys 0 and 1 in the same cycle
        t = cyc; expect_at("simul err", t + 7, H_E, 0, 0, 1);
        expect_at("simul end", t + 17, H_DASH, 0, 0, 1);
        press(3'b011);
        idle(2);

        // reset mid-entry, then a wrong first press
        t = cyc; expect_at("mid step1", t + 7, H_1, 0, 0, 1); press(3'b001);
        t = cyc; expect_at("mid step2", t + 7, H_2, 0, 0, 1); press(3'b010);
        t = cyc; expect_at("mid step3", t + 7, H_3, 0, 0, 1); press(3'b001);
        t = cyc;
        expect_at("mid reset", t + 1, H_DASH, 0, 0, 0);
        RESET_N = 1'b0;
        idle(1);
        RESET_N = 1'b1;
        idle(2);
        t = cyc; expect_at("post reset err", t + 7, H_E, 0, 0, 1);
        expect_at("post reset end", t + 17, H_DASH, 0, 0, 1);
        press(3'b100);
        idle(2);

        // unlocking clears the failure count; a press ends OPEN early
        t = cyc; expect_at("clr step1", t + 7, H_1, 0, 0, 1); press(3'b001);
        t = cyc; expect_at("clr step2", t + 7, H_2, 0, 0, 1); press(3'b010);
        t = cyc; expect_at("clr step3", t + 7, H_3, 0, 0, 1); press(3'b001);
        t = cyc; expect_at("clr open", t + 7, H_U, 1, 0, 0); press(3'b100);
        t = cyc; expect_at("open press exit", t + 7, H_DASH, 0, 0, 0); press(3'b001);
        idle(5);

        chk("scoreboard drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
